uart_tx_fifo: RTL and testbench

Byte buffer and launch sequencer sitting directly upstream of the UART transmitter. It accepts output bytes from the CPU core (Brainfuck '.' instruction) on a valid/ready interface and stores them in a circular FIFO. It drains the FIFO one byte at a time into the transmitter through the tx_start/tx_data/tx_busy handshake, so the core never stalls on a single in-flight character.

---
 rtl/uart_tx_fifo_pkg.sv | 12 +
 rtl/uart_tx_fifo_sync_fifo.sv | 60 ++++++
 rtl/uart_tx_fifo.sv | 101 ++++++++++
 tb/tb_uart_tx_fifo.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit buffer: launch FSM encoding and default depth.
package uart_tx_fifo_pkg;

    localparam int TXF_DEFAULT_DEPTH = 8;

    typedef enum logic [1:0] {
        TXF_IDLE      = 2'd0,
        TXF_WAIT_BUSY = 2'd1,
        TXF_WAIT_DONE = 2'd2
    } txf_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Circular register-array FIFO with separate occupancy counter; reusable for an RX buffer.
module sync_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int  DEPTH  = TXF_DEFAULT_DEPTH,
    parameter int  WIDTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [WIDTH-1:0]  push_data,
    input  logic              pop,
    output logic [WIDTH-1:0]  pop_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer between the core's '.' output and the UART transmitter, with a launch sequencer.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int  DEPTH  = TXF_DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_valid_i,
    input  logic [7:0]        wr_data_i,
    output logic              wr_ready_o,
    input  logic              flush_i,
    output logic              tx_start_o,
    output logic [7:0]        tx_data_o,
    input  logic              tx_busy_i,
    output logic              empty_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o,
    output logic [1:0]        dbg_state
);

    // Write handshake: a byte transfers on a rising edge where wr_valid_i && wr_ready_o;
    // wr_ready_o depends only on the stored count, never on wr_valid_i or a same-cycle pop.

    txf_state_e state;
    txf_state_e state_next;
    logic       start_next;
    logic [7:0] data_next;
    logic       overflow_next;
    logic       pop;
    logic       full;
    logic [7:0] head_data;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .flush     (flush_i),
        .push      (wr_valid_i),
        .push_data (wr_data_i),
        .pop       (pop),
        .pop_data  (head_data),
        .full      (full),
        .empty     (empty_o),
        .count     (count_o)
    );

    assign wr_ready_o = !full;
    assign dbg_state  = state;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= TXF_IDLE;
            tx_start_o <= 1'b0;
            tx_data_o  <= 8'h00;
            overflow_o <= 1'b0;
        end else begin
            state      <= state_next;
            tx_start_o <= start_next;
            tx_data_o  <= data_next;
            overflow_o <= overflow_next;
        end
    end

    // tx_busy_i only matters once a byte is in flight; IDLE ignores it.
    always_comb begin
        state_next    = state;
        start_next    = 1'b0;
        data_next     = tx_data_o;
        pop           = 1'b0;
        overflow_next = overflow_o;
        if (flush_i) begin
            overflow_next = 1'b0;
        end else if (wr_valid_i && full) begin
            overflow_next = 1'b1;
        end
        case (state)
            TXF_IDLE: begin
                if (!empty_o && !flush_i) begin
                    pop        = 1'b1;
                    start_next = 1'b1;
                    data_next  = head_data;
                    state_next = TXF_WAIT_BUSY;
                end
            end
            TXF_WAIT_BUSY: begin
                if (tx_busy_i) state_next = TXF_WAIT_DONE;
            end
            TXF_WAIT_DONE: begin
                if (!tx_busy_i) state_next = TXF_IDLE;
            end
            default: begin
                state_next = TXF_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural transmitter and an in-order byte scoreboard.
module tb_uart_tx_fifo;
    import uart_tx_fifo_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       flush;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       empty;
    logic [3:0] count;
    logic       overflow;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    int   busy_ticks = 10;
    bit   hold_busy  = 0;
    int   busy_cnt   = 0;
    logic start_seen;

    int   cyc = 0;
    int   last_busy_cyc = 0;
    bit   seen_busy = 0;
    logic prev_start = 0;
    int   start_cnt = 0;
    int   snap;

    uart_tx_fifo #(.DEPTH(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .wr_valid_i (wr_valid),
        .wr_data_i  (wr_data),
        .wr_ready_o (wr_ready),
        .flush_i    (flush),
        .tx_start_o (tx_start),
        .tx_data_o  (tx_data),
        .tx_busy_i  (tx_busy),
        .empty_o    (empty),
        .count_o    (count),
        .overflow_o (overflow),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // transmitter model: samples start at an edge, raises busy just after it
    always @(posedge clk) begin
        start_seen = tx_start;
        #1;
        if (!rst_n) begin
            busy_cnt = 0;
            tx_busy  = 1'b0;
        end else if (start_seen) begin
            busy_cnt = busy_ticks;
            tx_busy  = 1'b1;
        end else if (tx_busy && !hold_busy) begin
            if (busy_cnt <= 1) begin
                busy_cnt = 0;
                tx_busy  = 1'b0;
            end else begin
                busy_cnt--;
            end
        end
    end

    // scoreboard monitor on the inactive edge
    always @(negedge clk) begin
        cyc++;
        if (rst_n && tx_start) begin
            start_cnt++;
            check("start_width", prev_start, 1'b0);
            if (exp_q.size() == 0) check("unexpected_start", 1'b1, 1'b0);
            else                   check("tx_data_order", tx_data, exp_q.pop_front());
            if (seen_busy) check("idle_gap", (cyc - last_busy_cyc) >= 3, 1'b1);
        end
        if (tx_busy) begin
            last_busy_cyc = cyc;
            seen_busy = 1'b1;
        end
        prev_start = tx_start;
    end

    // driver tasks: called at a negedge, return at the following negedge
    task automatic send(input logic [7:0] d, input bit accept);
        check("wr_ready_before_write", wr_ready, accept);
        if (accept) exp_q.push_back(d);
        wr_valid = 1'b1;
        wr_data  = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int max_cyc);
        int n = 0;
        while (!(empty && dbg_state == TXF_IDLE && !tx_busy) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain_timeout"}, n < max_cyc, 1'b1);
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (!tx_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_busy_timeout"}, n < 20, 1'b1);
    endtask

    task automatic wait_idle_state(input string tag);
        int n = 0;
        while (dbg_state != TXF_IDLE && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_timeout"}, n < 50, 1'b1);
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        flush    = 1'b0;
        tx_busy  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_count", count, 4'd0);
        check("rst_empty", empty, 1'b1);
        check("rst_ready", wr_ready, 1'b1);
        check("rst_start", tx_start, 1'b0);
        check("rst_data", tx_data, 8'h00);
        check("rst_overflow", overflow, 1'b0);
        check("rst_state", dbg_state, TXF_IDLE);
        rst_n = 1'b1;
        @(negedge clk);

        // single byte latency
        send(8'h41, 1'b1);
        check("t1_count_after_write", count, 4'd1);
        check("t1_no_start_yet", tx_start, 1'b0);
        @(negedge clk);
        check("t1_start", tx_start, 1'b1);
        check("t1_data", tx_data, 8'h41);
        check("t1_count_after_pop", count, 4'd0);
        @(negedge clk);
        check("t1_start_one_cycle", tx_start, 1'b0);
        check("t1_data_held", tx_data, 8'h41);
        wait_drain("t1", 100);
        check("t1_empty", empty, 1'b1);

        // burst of eight bytes with a slow transmitter
        snap = start_cnt;
        for (int i = 1; i <= 8; i++) send(8'(i), 1'b1);
        wait_drain("t2", 400);
        check("t2_start_pulses", start_cnt - snap, 8);
        check("t2_queue_empty", exp_q.size(), 0);

        // fill while transmitter stalls, overflow, flush
        hold_busy = 1'b1;
        for (int i = 0; i < 9; i++) send(8'hA0 + 8'(i), 1'b1);
        check("t3_count_full", count, 4'd8);
        check("t3_ready_full", wr_ready, 1'b0);
        check("t3_no_overflow_yet", overflow, 1'b0);
        send(8'hA9, 1'b0);
        check("t3_count_still_full", count, 4'd8);
        check("t3_overflow", overflow, 1'b1);
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        @(negedge clk);
        flush    = 1'b0;
        wr_valid = 1'b0;
        exp_q.delete();
        check("t3_flush_count", count, 4'd0);
        check("t3_flush_overflow", overflow, 1'b0);
        check("t3_flush_empty", empty, 1'b1);
        check("t3_inflight_state", dbg_state, TXF_WAIT_DONE);
        snap = start_cnt;
        hold_busy = 1'b0;
        wait_drain("t3", 100);
        check("t3_no_new_start", start_cnt - snap, 0);
        check("t3_data_held", tx_data, 8'hA0);

        // push on the same edge as a launch pop with three stored
        hold_busy = 1'b1;
        send(8'hB0, 1'b1);
        wait_busy("t4");
        for (int i = 1; i <= 3; i++) send(8'hB0 + 8'(i), 1'b1);
        check("t4_count3", count, 4'd3);
        hold_busy = 1'b0;
        wait_idle_state("t4");
        send(8'hB4, 1'b1);
        check("t4_count_unchanged", count, 4'd3);
        check("t4_launch", tx_start, 1'b1);
        check("t4_launch_data", tx_data, 8'hB1);
        wait_drain("t4", 400);

        // reset in the middle of a frame
        hold_busy = 1'b1;
        send(8'hC0, 1'b1);
        wait_busy("t5");
        for (int i = 1; i <= 4; i++) send(8'hC0 + 8'(i), 1'b1);
        check("t5_count4", count, 4'd4);
        check("t5_state", dbg_state, TXF_WAIT_DONE);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        hold_busy = 1'b0;
        check("t5_rst_count", count, 4'd0);
        check("t5_rst_start", tx_start, 1'b0);
        check("t5_rst_overflow", overflow, 1'b0);
        check("t5_rst_empty", empty, 1'b1);
        check("t5_rst_state", dbg_state, TXF_IDLE);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        snap = start_cnt;
        repeat (20) @(negedge clk);
        check("t5_no_start_after_rst", start_cnt - snap, 0);

        // full FIFO, launch pop and rejected write on the same edge
        hold_busy = 1'b1;
        send(8'hD0, 1'b1);
        wait_busy("t6");
        for (int i = 1; i <= 8; i++) send(8'hD0 + 8'(i), 1'b1);
        check("t6_count8", count, 4'd8);
        hold_busy = 1'b0;
        wait_idle_state("t6");
        send(8'hD9, 1'b0);
        check("t6_count7", count, 4'd7);
        check("t6_overflow", overflow, 1'b1);
        check("t6_launch", tx_start, 1'b1);
        check("t6_launch_data", tx_data, 8'hD1);
        wait_drain("t6", 600);
        check("t6_overflow_sticky", overflow, 1'b1);
        check("t6_final_count", count, 4'd0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
